// File: rtl/axil_reg_slave.sv
// AXI-lite register bank responder.
// Word 0 returns a fixed ID, word 1 returns the live status input, and
// words 2..NUM_REGS-1 are read/write control registers exported to the
// peripheral logic together with a one-cycle write strobe per word.
module axil_reg_slave #(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
   parameter logic [31:0] ID_VALUE  = 32'h5256_0001
) (
   input  logic                   clk,
   input  logic                   rstf,
   input  logic [31:0]            s_axi_awaddr,
   input  logic [2:0]             s_axi_awprot,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [31:0]            s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [31:0]            s_axi_araddr,
   input  logic [2:0]             s_axi_arprot,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [31:0]            s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   input  logic [31:0]            status_in,
   output logic [NUM_REGS*32-1:0] reg_q,
   output logic [NUM_REGS-1:0]    reg_wr_pulse
);

   localparam int unsigned IDX_W     = $clog2(NUM_REGS);
   localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;

   // True when the byte address falls inside the register window.
   function automatic logic addr_hit(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return (off < WIN_BYTES);
   endfunction

   // Word index inside the window; the two byte-offset bits are ignored.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return off[IDX_W+1:2];
   endfunction

   wstate_t       w_state_q;
   logic          awready_q, wready_q, bvalid_q;
   logic [1:0]    bresp_q;
   logic [31:0]   awaddr_q, wdata_q;
   logic [3:0]    wstrb_q;
   logic [31:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] pulse_q;

   logic          arready_q, rvalid_q;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    rresp_q, rresp_d;

   logic             aw_hs, w_hs, ar_hs, have_aw, have_w, commit, cm_ok;
   logic [31:0]      cm_addr, cm_data;
   logic [3:0]       cm_strb;
   logic [IDX_W-1:0] cm_idx, rd_idx;
   logic             unused_inputs;

   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot};

   // Write-side handshakes and the merged address/data seen by the commit.
   always_comb begin
      aw_hs   = s_axi_awvalid && awready_q;
      w_hs    = s_axi_wvalid && wready_q;
      have_aw = aw_hs || (w_state_q == W_HAVE_AW);
      have_w  = w_hs || (w_state_q == W_HAVE_W);
      commit  = have_aw && have_w;
      cm_addr = aw_hs ? s_axi_awaddr : awaddr_q;
      cm_data = w_hs ? s_axi_wdata : wdata_q;
      cm_strb = w_hs ? s_axi_wstrb : wstrb_q;
      cm_idx  = addr_idx(cm_addr);
      cm_ok   = addr_hit(cm_addr) && (cm_idx > IDX_W'(1));
   end

   // Write channel FSM: collect AW and W in any order, then hold B until accepted.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE, W_HAVE_AW, W_HAVE_W: begin
               if (aw_hs) awaddr_q <= s_axi_awaddr;
               if (w_hs) begin
                  wdata_q <= s_axi_wdata;
                  wstrb_q <= s_axi_wstrb;
               end
               if (commit) begin
                  w_state_q <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= cm_ok ? RESP_OKAY : RESP_SLV;
               end else if (have_aw) begin
                  w_state_q <= W_HAVE_AW;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (have_w) begin
                  w_state_q <= W_HAVE_W;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  w_state_q <= W_IDLE;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  w_state_q <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Register bank update with byte enables, plus the per-word write pulse.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (commit && cm_ok) begin
            for (int b = 0; b < 4; b++) begin
               if (cm_strb[b]) regs_q[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
            end
            if (cm_strb != 4'b0000) pulse_q[cm_idx] <= 1'b1;
         end
      end
   end

   // Read data source selection for the address presented on AR.
   always_comb begin
      rd_idx  = addr_idx(s_axi_araddr);
      rdata_d = '0;
      rresp_d = RESP_SLV;
      if (addr_hit(s_axi_araddr)) begin
         rresp_d = RESP_OKAY;
         if (rd_idx == '0)             rdata_d = ID_VALUE;
         else if (rd_idx == IDX_W'(1)) rdata_d = status_in;
         else                          rdata_d = regs_q[rd_idx];
      end
   end

   // Read channel: capture data on AR, hold it until R is accepted.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else if (ar_hs) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b1;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end else if (rvalid_q && s_axi_rready) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
      end else if (!rvalid_q) begin
         arready_q <= 1'b1;
      end
   end

   assign ar_hs = s_axi_arvalid && arready_q;

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign reg_wr_pulse  = pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
      assign reg_q[32*g +: 32] = regs_q[g];
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: table of single transactions plus hand-written
// multi-cycle sequences, with expected responses queued when driven.
module tb_axil_reg_slave;

   localparam int          NR   = 16;
   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam logic [31:0] IDV  = 32'h5256_0001;

   logic clk = 1'b0;
   logic rstf;
   logic [31:0] awaddr, wdata, araddr, rdata, status_in;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0]  bq [$];
   logic [33:0] rq [$];
   logic [31:0] mdl [NR];

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;     // write data, or status_in for reads
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vec [15];

   always #5 clk = ~clk;

   axil_reg_slave #(.NUM_REGS(NR), .BASE_ADDR(BASE), .ID_VALUE(IDV)) dut (
      .clk(clk), .rstf(rstf),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .status_in(status_in), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR*32-1:0] mdl_vec();
      logic [NR*32-1:0] v;
      for (int i = 0; i < NR; i++) v[32*i +: 32] = (i < 2) ? 32'h0 : mdl[i];
      return v;
   endfunction

   task automatic chk_regs(input string name);
      n_cmp++;
      if (reg_q !== mdl_vec()) begin
         n_err++;
         $display("FAIL %s: reg_q got %h expected %h", name, reg_q, mdl_vec());
      end
   endtask

   function automatic bit w_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off < 32'(NR*4)) && ((off >> 2) >= 2);
   endfunction

   function automatic logic [1:0] exp_bresp(input logic [31:0] a);
      return w_ok(a) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [NR-1:0] exp_pulse(input logic [31:0] a, input logic [3:0] s);
      logic [NR-1:0] p;
      logic [31:0]   off;
      p   = '0;
      off = a - BASE;
      if (w_ok(a) && s != 4'h0) p[off >> 2] = 1'b1;
      return p;
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] off;
      off = a - BASE;
      if (w_ok(a))
         for (int b = 0; b < 4; b++) if (s[b]) mdl[off >> 2][8*b +: 8] = d[8*b +: 8];
   endtask

   function automatic logic [33:0] exp_rd(input logic [31:0] a, input logic [31:0] st);
      logic [31:0] off;
      off = a - BASE;
      if (off >= 32'(NR*4)) return {32'h0, 2'b10};
      if ((off >> 2) == 0) return {IDV, 2'b00};
      if ((off >> 2) == 1) return {st, 2'b00};
      return {mdl[off >> 2], 2'b00};
   endfunction

   task automatic pop_b(output logic [1:0] e);
      if (bq.size() == 0) begin
         n_cmp++; n_err++; e = 2'bxx;
         $display("FAIL bq_empty: got bvalid=%0b expected no response", bvalid);
      end else e = bq.pop_front();
   endtask

   task automatic pop_r(output logic [33:0] e);
      if (rq.size() == 0) begin
         n_cmp++; n_err++; e = 'x;
         $display("FAIL rq_empty: got rvalid=%0b expected no response", rvalid);
      end else e = rq.pop_front();
   endtask

   task automatic wait_out(input bit is_b, output int lat);
      lat = 0;
      while (!(is_b ? bvalid : rvalid) && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   // Same-cycle AW+W write with bready high; expected bresp already queued.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n, lat;
      logic [1:0] e;
      logic [NR-1:0] ep;
      ep = exp_pulse(a, s);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      wait_out(1'b1, lat);
      chk("b_latency", 64'(lat), 64'd0);
      pop_b(e);
      chk("bresp", 64'(bresp), 64'(e));
      chk("wr_pulse", 64'(reg_wr_pulse), 64'(ep));
      mdl_write(a, d, s);
      chk_regs("reg_q_after_write");
      @(posedge clk); #1;
      chk("bvalid_clear", 64'(bvalid), 64'd0);
      chk("pulse_one_cycle", 64'(reg_wr_pulse), 64'd0);
   endtask

   // Single read with rready high; expected {rdata,rresp} already queued.
   task automatic do_read(input logic [31:0] a);
      int n, lat;
      logic [33:0] e;
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      wait_out(1'b0, lat);
      chk("r_latency", 64'(lat), 64'd0);
      pop_r(e);
      chk("rdata", 64'(rdata), 64'(e[33:2]));
      chk("rresp", 64'(rresp), 64'(e[1:0]));
      @(posedge clk); #1;
      chk("rvalid_clear", 64'(rvalid), 64'd0);
      chk("arready_back", 64'(arready), 64'd1);
   endtask

   initial begin
      logic [1:0]    eb;
      logic [33:0]   er;
      logic [NR-1:0] ep;

      vec[0]  = '{1'b1, BASE + 32'd8,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
      vec[1]  = '{1'b0, BASE + 32'd8,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
      vec[2]  = '{1'b1, BASE,          32'h12345678, 4'hF, 32'h0,        2'b10};
      vec[3]  = '{1'b1, BASE + 32'd64, 32'h12345678, 4'hF, 32'h0,        2'b10};
      vec[4]  = '{1'b0, BASE,          32'h0,        4'h0, IDV,          2'b00};
      vec[5]  = '{1'b0, BASE - 32'd4,  32'h0,        4'h0, 32'h0,        2'b10};
      vec[6]  = '{1'b1, BASE + 32'd60, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
      vec[7]  = '{1'b0, BASE + 32'd60, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
      vec[8]  = '{1'b1, BASE + 32'd16, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
      vec[9]  = '{1'b0, BASE + 32'd16, 32'h0,        4'h0, 32'h0,        2'b00};
      vec[10] = '{1'b1, BASE + 32'h13, 32'hA5A5A5A5, 4'h8, 32'h0,        2'b00};
      vec[11] = '{1'b0, BASE + 32'd16, 32'h0,        4'h0, 32'hA5000000, 2'b00};
      vec[12] = '{1'b0, BASE + 32'd4,  32'h0BADF00D, 4'h0, 32'h0BADF00D, 2'b00};
      vec[13] = '{1'b0, BASE + 32'd64, 32'h0,        4'h0, 32'h0,        2'b10};
      vec[14] = '{1'b1, BASE + 32'd4,  32'h55555555, 4'hF, 32'h0,        2'b10};

      for (int i = 0; i < NR; i++) mdl[i] = '0;
      rstf = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; status_in = '0;
      awprot = '0; arprot = '0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready",  64'(wready),  64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_valids",  64'({bvalid, rvalid}), 64'd0);
      chk("rst_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
      chk("rst_pulse",   64'(reg_wr_pulse), 64'd0);
      chk_regs("rst_regs");
      rstf = 1'b1;
      #2;
      chk("ready_before_edge", 64'({awready, wready, arready}), 64'd0);
      @(posedge clk); #1;
      chk("ready_after_release", 64'({awready, wready, arready}), 64'h7);

      for (int i = 0; i < 15; i++) begin
         if (vec[i].is_wr) begin
            bq.push_back(vec[i].exp_resp);
            do_write(vec[i].addr, vec[i].data, vec[i].strb);
         end else begin
            status_in = vec[i].data;
            rq.push_back({vec[i].exp_data, vec[i].exp_resp});
            do_read(vec[i].addr);
         end
      end

      // W arrives three cycles ahead of AW, partial strobes on pre-set word 3
      bq.push_back(exp_bresp(BASE + 32'd12));
      do_write(BASE + 32'd12, 32'hAABBCCDD, 4'hF);
      wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      chk("w_first_wready", 64'(wready), 64'd0);
      chk("w_first_awready", 64'(awready), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
      chk("w_first_hold", 64'({awready, wready, bvalid}), 64'b100);
      bq.push_back(exp_bresp(BASE + 32'd12));
      ep = exp_pulse(BASE + 32'd12, 4'b0101);
      awaddr = BASE + 32'd12; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      chk("w_first_bvalid", 64'(bvalid), 64'd1);
      pop_b(eb);
      chk("w_first_bresp", 64'(bresp), 64'(eb));
      chk("w_first_pulse", 64'(reg_wr_pulse), 64'(ep));
      chk("w_first_word3", 64'(reg_q[3*32 +: 32]), 64'h00000000AA22CC44);
      mdl_write(BASE + 32'd12, 32'h11223344, 4'b0101);
      @(posedge clk); #1;
      chk("w_first_bdone", 64'(bvalid), 64'd0);

      // Back-pressure on B: response and readies hold while bready is low
      bready = 1'b0;
      bq.push_back(exp_bresp(BASE + 32'd28));
      awaddr = BASE + 32'd28; wdata = 32'h55AA55AA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      mdl_write(BASE + 32'd28, 32'h55AA55AA, 4'hF);
      pop_b(eb);
      for (int k = 0; k < 5; k++) begin
         chk("bhold_valid_readies", 64'({bvalid, awready, wready}), 64'b100);
         chk("bhold_bresp", 64'(bresp), 64'(eb));
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(posedge clk); #1;
      chk("bhold_release", 64'({bvalid, awready, wready}), 64'b011);
      chk_regs("bhold_regs");

      // Back-pressure on R: sampled status stays put while status_in toggles
      rready = 1'b0;
      status_in = 32'h11110000;
      rq.push_back(exp_rd(BASE + 32'd4, status_in));
      araddr = BASE + 32'd4; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      pop_r(er);
      for (int k = 0; k < 4; k++) begin
         status_in = ~status_in;
         chk("rhold_valid_arready", 64'({rvalid, arready}), 64'b10);
         chk("rhold_rdata", 64'(rdata), 64'(er[33:2]));
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      chk("rhold_release", 64'({rvalid, arready}), 64'b01);

      // Read of word 5 on the same edge as its write commit sees the old value
      bq.push_back(exp_bresp(BASE + 32'd20));
      rq.push_back(exp_rd(BASE + 32'd20, status_in));
      awaddr = BASE + 32'd20; wdata = 32'h00001234; wstrb = 4'hF;
      araddr = BASE + 32'd20;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      mdl_write(BASE + 32'd20, 32'h00001234, 4'hF);
      chk("coll_valids", 64'({bvalid, rvalid}), 64'b11);
      pop_b(eb);
      chk("coll_bresp", 64'(bresp), 64'(eb));
      pop_r(er);
      chk("coll_old_data", 64'(rdata), 64'(er[33:2]));
      chk("coll_old_is_zero", 64'(rdata), 64'd0);
      @(posedge clk); #1;
      rq.push_back({32'h00001234, 2'b00});
      do_read(BASE + 32'd20);

      // Reset while both B and R are pending discards everything
      bready = 1'b0; rready = 1'b0;
      awaddr = BASE + 32'd24; wdata = 32'h00000077; wstrb = 4'hF;
      araddr = BASE + 32'd8;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("pre_rst_valids", 64'({bvalid, rvalid}), 64'b11);
      #2;
      rstf = 1'b0;
      #1;
      chk("async_rst_valids", 64'({bvalid, rvalid}), 64'd0);
      chk("async_rst_readies", 64'({awready, wready, arready}), 64'd0);
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      chk_regs("async_rst_regs");
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      rstf = 1'b1;
      #2;
      chk("rel_ready_before_edge", 64'({awready, wready, arready}), 64'd0);
      @(posedge clk); #1;
      chk("rel_ready_after_edge", 64'({awready, wready, arready}), 64'h7);
      chk("rel_no_response", 64'({bvalid, rvalid}), 64'd0);
      rq.push_back(exp_rd(BASE + 32'd8, status_in));
      do_read(BASE + 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
